regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads 0 and ignores writes.
REQ-005 The block SHALL have parameter SP_IDX, default 29, index loaded with SP_INIT during initialisation.
REQ-006 The block SHALL have parameter SP_INIT, default 32'h000007fc, init value of entry SP_IDX; all other entries init to 0.
REQ-007 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-008 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 The block SHALL have port clear, input, 1, synchronous request to re-run initialisation.
REQ-010 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd_data, output, NUM_RD*DATA_W, packed combinational read data.
REQ-012 The block SHALL have port rd_busy, output, NUM_RD, per-port scoreboard-pending flag.
REQ-013 The block SHALL have ports wr0_en/wr1_en (input, 1), wr0_addr/wr1_addr (input, ADDR_W), wr0_data/wr1_data (input, DATA_W), two write ports.
REQ-014 The block SHALL have ports rsv_en (input, 1) and rsv_addr (input, ADDR_W), marking a destination as pending.
REQ-015 The block SHALL have port ready, output, 1, high when in READY state.
REQ-016 The block SHALL have port wr_drop, output, 1, registered one-cycle pulse when any write or reserve is discarded.

Function
REQ-017 The FSM SHALL have states INIT and READY; ready = (state == READY).
REQ-018 INIT SHALL write init value to entry cnt each cycle, cnt counting 0..DEPTH-1, then move to READY on the cycle after cnt = DEPTH-1 is written (DEPTH cycles in INIT).
REQ-019 In READY, clear = 1 SHALL move to INIT with cnt = 0 and all pending bits cleared on the next edge; clear in INIT SHALL restart cnt at 0.
REQ-020 In INIT, wr0/wr1/rsv requests SHALL be discarded, wr_drop asserted next cycle, rd_data = 0, rd_busy = 0.
REQ-021 In READY, an enabled write to a writable address SHALL update the entry at the clock edge; writes to entry 0 with ZERO_REG=1 SHALL be ignored without wr_drop.
REQ-022 wr0 and wr1 to the same writable address in one cycle SHALL store wr1_data.
REQ-023 Read port k SHALL return, in priority: 0 if ZERO_REG and address 0; wr1_data on same-cycle wr1 hit; wr0_data on wr0 hit; else stored entry.
REQ-024 Pending bit SHALL be set by rsv_en in READY (not for entry 0 with ZERO_REG) and cleared by a write to that address; same-cycle reserve and write to one address SHALL leave it set.
REQ-025 rd_busy[k] SHALL equal pending[addr_k] AND NOT same-cycle write hit to addr_k; always 0 for entry 0 with ZERO_REG.
REQ-026 Address arithmetic SHALL be unsigned ADDR_W-bit; cnt SHALL be ADDR_W+1 bits to avoid wrap at DEPTH-1.

Reset
REQ-027 reset SHALL asynchronously force state INIT, cnt 0, all pending bits 0, wr_drop 0; array contents need not be reset (INIT overwrites them).
REQ-028 reset asserted mid-INIT or mid-write SHALL abort the operation; initialisation restarts from cnt 0 after release.

Verification
REQ-029 Release reset -> ready low for exactly DEPTH (32) cycles, then high; read entry 29 -> 32'h000007fc, entry 5 -> 0.
REQ-030 READY, wr0 addr 3 data 32'hA5A5A5A5 while port 0 reads 3 -> rd_data0 = 32'hA5A5A5A5 same cycle; next cycle stored value read back.
REQ-031 wr0 (addr 7, 32'h1) and wr1 (addr 7, 32'h2) same cycle -> forwarded and stored value 32'h2; wr to addr 0 -> reads 0.
REQ-032 rsv addr 9 -> rd_busy high on port reading 9; write addr 9 -> rd_busy low that cycle, pending cleared; simultaneous rsv+write addr 9 -> stays busy.
REQ-033 Write during INIT or assert clear with entry 4 = 32'hDEAD -> wr_drop pulse, entry 4 = 0 after re-init, pending cleared.
REQ-034 Assert reset at cnt = 10 of INIT -> after release, full DEPTH-cycle INIT observed before ready.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a DEPTH-cycle initialisation sweep, same-cycle
// write forwarding and a per-entry pending scoreboard for reserved destinations.

module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                           ready,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]   mem,
  input  logic [DEPTH-1:0]               pend,
  input  logic                           wr0_ok,
  input  logic [ADDR_W-1:0]              wr0_addr,
  input  logic [DATA_W-1:0]              wr0_data,
  input  logic                           wr1_ok,
  input  logic [ADDR_W-1:0]              wr1_addr,
  input  logic [DATA_W-1:0]              wr1_data,
  output logic [DATA_W-1:0]              data,
  output logic                           busy
);
  logic hit0, hit1, live;

  assign hit0 = wr0_ok && (wr0_addr == addr);
  assign hit1 = wr1_ok && (wr1_addr == addr);
  assign live = ready && !(ZERO_REG != 0 && addr == '0);

  // wr1 outranks wr0 so forwarding matches what the array will hold next cycle
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (live) begin
      if (hit1)      data = wr1_data;
      else if (hit0) data = wr0_data;
      else           data = mem[addr];
      busy = pend[addr] && !(hit0 || hit1);
    end
  end
endmodule

module regfile_mp #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_RD   = 2,
  parameter int                ZERO_REG = 1,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h000007fc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     ready,
  output logic                     wr_drop
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {INIT, READY} state_t;

  state_t                      state, state_nx;
  logic [ADDR_W:0]             cnt, cnt_nx;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]            pend, pend_nx;
  logic                        drop_nx;
  logic                        wr0_ok, wr1_ok, rsv_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(SP_IDX)) ? SP_INIT : '0;
  endfunction

  assign ready  = (state == READY);
  assign wr0_ok = ready && wr0_en && writable(wr0_addr);
  assign wr1_ok = ready && wr1_en && writable(wr1_addr);
  assign rsv_ok = ready && rsv_en && writable(rsv_addr);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    drop_nx  = 1'b0;
    case (state)
      INIT: begin
        drop_nx = wr0_en || wr1_en || rsv_en;
        pend_nx = '0;
        if (clear) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = READY;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          state_nx = INIT;
          cnt_nx   = '0;
          pend_nx  = '0;
        end else begin
          // clear-on-write first, then set, so reserve+write leaves it pending
          if (wr0_ok) pend_nx[wr0_addr] = 1'b0;
          if (wr1_ok) pend_nx[wr1_addr] = 1'b0;
          if (rsv_ok) pend_nx[rsv_addr] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= '0;
      pend    <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      wr_drop <= drop_nx;
    end
  end

  // Array is not reset; the INIT sweep overwrites it. reset gates the edge
  // so a write coinciding with reset is aborted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt[ADDR_W-1:0]] <= init_val(cnt[ADDR_W-1:0]);
      end else begin
        if (wr0_ok) mem[wr0_addr] <= wr0_data;
        if (wr1_ok) mem[wr1_addr] <= wr1_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .ready    (ready),
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem      (mem),
      .pend     (pend),
      .wr0_ok   (wr0_ok),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_ok   (wr1_ok),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .data     (rd_data[k*DATA_W +: DATA_W]),
      .busy     (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver predicts each cycle's outputs from an
// abstract model into a queue; a negedge monitor pops and compares.

module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset, clear, wr0_en, wr1_en, rsv_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              ready, wr_drop;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clear(clear),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(ready), .wr_drop(wr_drop)
  );

  typedef struct packed {
    logic rst, clear, wr0_en, wr1_en, rsv_en;
    logic [AW-1:0] wr0_addr, wr1_addr, rsv_addr, ra0, ra1;
    logic [DW-1:0] wr0_data, wr1_data;
  } stim_t;

  typedef struct packed {
    logic ready, drop;
    logic [NR-1:0] busy;
    logic [NR*DW-1:0] data;
  } exp_t;

  exp_t expq[$];
  int nchk = 0, nfail = 0, cyc = 0;

  // Abstract model: architectural contents, pending set, and INIT cycles left
  logic [DW-1:0] mem_m[DEPTH];
  bit            pend_m[DEPTH];
  bit            in_init, exp_drop;
  int            init_left;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    in_init   = 1'b1;
    init_left = DEPTH;
    exp_drop  = 1'b0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
  endtask

  function automatic exp_t predict(stim_t s);
    exp_t e;
    logic [AW-1:0] a;
    bit hit;
    e = '0;
    e.ready = !in_init;
    e.drop  = exp_drop;
    for (int k = 0; k < NR; k++) begin
      a   = (k == 0) ? s.ra0 : s.ra1;
      hit = (s.wr0_en && s.wr0_addr == a) || (s.wr1_en && s.wr1_addr == a);
      if (!in_init && a != 0) begin
        if (s.wr1_en && s.wr1_addr == a)      e.data[k*DW +: DW] = s.wr1_data;
        else if (s.wr0_en && s.wr0_addr == a) e.data[k*DW +: DW] = s.wr0_data;
        else                                  e.data[k*DW +: DW] = mem_m[a];
        e.busy[k] = pend_m[a] && !hit;
      end
    end
    return e;
  endfunction

  task automatic model_step(stim_t s);
    bit drop_n;
    if (s.rst) begin
      model_reset();
      return;
    end
    drop_n = in_init && (s.wr0_en || s.wr1_en || s.rsv_en);
    if (in_init) begin
      if (s.clear) init_left = DEPTH;
      else begin
        init_left--;
        if (init_left == 0) begin
          in_init = 1'b0;
          for (int i = 0; i < DEPTH; i++) mem_m[i] = (i == 29) ? 32'h000007fc : 32'h0;
        end
      end
    end else if (s.clear) begin
      in_init   = 1'b1;
      init_left = DEPTH;
      foreach (pend_m[i]) pend_m[i] = 1'b0;
    end else begin
      if (s.wr0_en && s.wr0_addr != 0) begin mem_m[s.wr0_addr] = s.wr0_data; pend_m[s.wr0_addr] = 1'b0; end
      if (s.wr1_en && s.wr1_addr != 0) begin mem_m[s.wr1_addr] = s.wr1_data; pend_m[s.wr1_addr] = 1'b0; end
      if (s.rsv_en && s.rsv_addr != 0) pend_m[s.rsv_addr] = 1'b1;
    end
    exp_drop = drop_n;
  endtask

  // Called just after a rising edge: drive, predict, advance one clock
  task automatic do_cycle(input stim_t s);
    reset = s.rst; clear = s.clear;
    wr0_en = s.wr0_en; wr0_addr = s.wr0_addr; wr0_data = s.wr0_data;
    wr1_en = s.wr1_en; wr1_addr = s.wr1_addr; wr1_data = s.wr1_data;
    rsv_en = s.rsv_en; rsv_addr = s.rsv_addr;
    rd_addr = {s.ra1, s.ra0};
    if (s.rst) model_reset();
    expq.push_back(predict(s));
    @(posedge clk); #1;
    cyc++;
    model_step(s);
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = '0;
    s.wr0_en = 1'($urandom_range(0, 1));   s.wr0_addr = raddr(); s.wr0_data = $urandom;
    s.wr1_en = ($urandom_range(0, 3) == 0); s.wr1_addr = raddr(); s.wr1_data = $urandom;
    s.rsv_en = ($urandom_range(0, 2) == 0); s.rsv_addr = raddr();
    s.clear  = ($urandom_range(0, 149) == 0);
    s.ra0 = raddr(); s.ra1 = raddr();
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("ready",   64'(ready),           64'(e.ready));
        check("wr_drop", 64'(wr_drop),         64'(e.drop));
        check("rd_busy", 64'(rd_busy),         64'(e.busy));
        check("rd_data0", 64'(rd_data[31:0]),  64'(e.data[31:0]));
        check("rd_data1", 64'(rd_data[63:32]), 64'(e.data[63:32]));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  stim_t st;

  initial begin : driver
    reset = 1'b1; clear = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0; wr0_data = '0; wr1_data = '0; rd_addr = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset, then the full init sweep; SP entry and a zero entry read back
    st = '0; st.rst = 1'b1; st.ra0 = 5'd29; st.ra1 = 5'd5;
    repeat (3) do_cycle(st);
    st.rst = 1'b0;
    repeat (DEPTH + 2) do_cycle(st);

    // Same-cycle forwarding then stored read-back
    st = '0; st.wr0_en = 1'b1; st.wr0_addr = 5'd3; st.wr0_data = 32'hA5A5A5A5; st.ra0 = 5'd3;
    do_cycle(st);
    st = '0; st.ra0 = 5'd3; do_cycle(st);

    // Dual write to one address: wr1 wins; writes to entry 0 are ignored
    st = '0; st.wr0_en = 1'b1; st.wr0_addr = 5'd7; st.wr0_data = 32'h1;
    st.wr1_en = 1'b1; st.wr1_addr = 5'd7; st.wr1_data = 32'h2; st.ra0 = 5'd7;
    do_cycle(st);
    st = '0; st.ra0 = 5'd7; st.ra1 = 5'd0; st.wr0_en = 1'b1; st.wr0_addr = 5'd0; st.wr0_data = 32'hFFFF;
    do_cycle(st);
    st = '0; st.ra1 = 5'd0; do_cycle(st);

    // Scoreboard: reserve, clear-by-write, reserve+write stays pending
    st = '0; st.rsv_en = 1'b1; st.rsv_addr = 5'd9; st.ra0 = 5'd9; do_cycle(st);
    st = '0; st.ra0 = 5'd9; do_cycle(st);
    st.wr0_en = 1'b1; st.wr0_addr = 5'd9; st.wr0_data = 32'h99; do_cycle(st);
    st = '0; st.ra0 = 5'd9; do_cycle(st);
    st.rsv_en = 1'b1; st.rsv_addr = 5'd9; st.wr1_en = 1'b1; st.wr1_addr = 5'd9; st.wr1_data = 32'h77;
    do_cycle(st);
    st = '0; st.ra0 = 5'd9; do_cycle(st);

    // clear with entry 4 = DEAD and 9 pending; write during INIT is dropped
    st = '0; st.wr0_en = 1'b1; st.wr0_addr = 5'd4; st.wr0_data = 32'hDEAD; st.ra0 = 5'd4; st.ra1 = 5'd9;
    do_cycle(st);
    st = '0; st.clear = 1'b1; st.ra0 = 5'd4; st.ra1 = 5'd9; do_cycle(st);
    st = '0; st.wr0_en = 1'b1; st.wr0_addr = 5'd4; st.wr0_data = 32'hBEEF; st.ra0 = 5'd4; st.ra1 = 5'd9;
    do_cycle(st);
    st.wr0_en = 1'b0; st.rsv_en = 1'b1; st.rsv_addr = 5'd9; do_cycle(st);
    st.rsv_en = 1'b0;
    repeat (DEPTH) do_cycle(st);

    // Reset at cnt = 10 of INIT, then a full sweep again
    st = '0; st.clear = 1'b1; do_cycle(st);
    st.clear = 1'b0; st.ra0 = 5'd29;
    repeat (10) do_cycle(st);
    st.rst = 1'b1; repeat (2) do_cycle(st);
    st.rst = 1'b0; repeat (DEPTH + 2) do_cycle(st);

    // Randomised traffic
    repeat (500) do_cycle(rnd());

    @(negedge clk); #1;
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
